// File: rtl/dp_sequencer_pkg.sv
// Shared definitions for the datapath sequencer: FSM encoding, ALU opcodes, default width.
package dp_sequencer_pkg;

  // Default register-file / RAM address width.
  localparam int unsigned ADDR_W_DEFAULT = 6;

  // ALU operation codes.
  localparam logic [4:0] ALU_OP_NOP = 5'b00000;
  localparam logic [4:0] ALU_OP_ADD = 5'b00001;
  localparam logic [4:0] ALU_OP_SUB = 5'b00010;
  localparam logic [4:0] ALU_OP_AND = 5'b00011;
  localparam logic [4:0] ALU_OP_OR  = 5'b00100;
  localparam logic [4:0] ALU_OP_XOR = 5'b00101;

  // Sequencer FSM states, 3-bit encoding.
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StExec = 3'd1,
    StWait = 3'd2,
    StWb   = 3'd3,
    StDone = 3'd4
  } dp_state_e;

endpackage

// File: rtl/dp_sequencer.sv
// Sequencer computing r[k] = r[k-2] op r[k-1] over a range of addresses.
// Each result: EXEC (ALU result written to RAM[k]), WAIT (RAM port-B read latency),
// WB (read-back written to reg[k]).
module dp_sequencer
  import dp_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter logic [4:0]  ALU_OP = ALU_OP_ADD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] count,
  output logic [ADDR_W-1:0] addr1,
  output logic [ADDR_W-1:0] addr2,
  output logic [ADDR_W-1:0] addr3,
  output logic [4:0]        alu_op,
  output logic              wea,
  output logic              wer,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] KMax = {ADDR_W{1'b1}};

  dp_state_e         state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  // err_q: rejected start (pulse next cycle) or overflow (pulse during DONE).
  logic              err_q, err_d;
  // zdone_q: done pulse for an accepted zero-length request, which never leaves IDLE.
  logic              zdone_q, zdone_d;

  // State, address counter and remaining counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      k_q     <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      zdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      zdone_q <= zdone_d;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    rem_d   = rem_q;
    err_d   = 1'b0;
    zdone_d = 1'b0;
    addr1   = '0;
    addr2   = '0;
    addr3   = '0;
    wea     = 1'b0;
    wer     = 1'b0;
    busy    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (base < ADDR_W'(2)) begin
            err_d = 1'b1;
          end else if (count == '0) begin
            zdone_d = 1'b1;
          end else begin
            k_d     = base;
            rem_d   = count;
            state_d = StExec;
          end
        end
      end
      StExec: begin
        addr1   = k_q - ADDR_W'(2);
        addr2   = k_q - ADDR_W'(1);
        addr3   = k_q;
        wea     = 1'b1;
        busy    = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        addr3   = k_q;
        busy    = 1'b1;
        state_d = StWb;
      end
      StWb: begin
        addr3 = k_q;
        wer   = 1'b1;
        busy  = 1'b1;
        rem_d = rem_q - ADDR_W'(1);
        if (rem_q == ADDR_W'(1)) begin
          state_d = StDone;
        end else if (k_q == KMax) begin
          // Top of the address space reached with work left: stop rather than wrap.
          state_d = StDone;
          err_d   = 1'b1;
        end else begin
          k_d     = k_q + ADDR_W'(1);
          state_d = StExec;
        end
      end
      StDone: begin
        busy    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    done   = zdone_q | (state_q == StDone);
    err    = err_q;
    alu_op = ALU_OP;
  end

  // The two write strobes are mutually exclusive by construction.
  assert property (@(posedge clk) disable iff (!rst_n) !(wea && wer));

endmodule

// File: tb/tb_dp_sequencer.sv
// Self-checking bench for dp_sequencer with a behavioural register file, ALU and RAM.
module tb_dp_sequencer;
  import dp_sequencer_pkg::*;

  localparam int unsigned AW = 6;
  localparam int unsigned OW = 3 * AW + 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW-1:0] count = '0;
  logic [AW-1:0] addr1, addr2, addr3;
  logic [4:0]    alu_op;
  logic          wea, wer, busy, done, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dp_sequencer #(
    .ADDR_W(AW),
    .ALU_OP(ALU_OP_ADD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .base  (base),
    .count (count),
    .addr1 (addr1),
    .addr2 (addr2),
    .addr3 (addr3),
    .alu_op(alu_op),
    .wea   (wea),
    .wer   (wer),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  // Datapath model: 2R/1W register file, adder ALU, RAM with 1-cycle port-B read.
  logic [15:0] rf  [64];
  logic [15:0] ram [64];
  logic [15:0] doutb;
  logic [15:0] alu_y;
  logic        preload = 1'b0;

  assign alu_y = rf[addr1] + rf[addr2];

  // Write port updates and registered RAM read.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) begin
        rf[i]  <= (i < 2) ? 16'd1 : 16'd0;
        ram[i] <= 16'd0;
      end
    end else begin
      if (wea) ram[addr3] <= alu_y;
      if (wer) rf[addr3] <= doutb;
    end
    doutb <= ram[addr3];
  end

  typedef struct {
    logic          start;
    logic [AW-1:0] base;
    logic [AW-1:0] count;
    logic [OW-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input int b, input int c, input int a1,
                              input int a2, input int a3, input logic e_wea, input logic e_wer,
                              input logic e_busy, input logic e_done, input logic e_err);
    vec_t v;
    v.start = s;
    v.base  = AW'(b);
    v.count = AW'(c);
    v.exp   = {AW'(a1), AW'(a2), AW'(a3), e_wea, e_wer, e_busy, e_done, e_err};
    return v;
  endfunction

  function automatic logic [OW-1:0] outs();
    return {addr1, addr2, addr3, wea, wer, busy, done, err};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;

    // Reset state.
    preload = 1'b1;
    step();
    step();
    check("reset_outputs", 32'(outs()), 32'd0);
    check("alu_op", 32'(alu_op), 32'd1);
    preload = 1'b0;
    rst_n   = 1'b1;
    step();

    // Run: base=2 count=4, done 13 cycles after the accepting cycle.
    vecs.push_back(mk(1, 2, 4, 0, 1, 2, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 2, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 2, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2, 3, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 3, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 2, 3, 4, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 3, 4, 5, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 5, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 5, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Rejected start (base<2): err pulse only.
    vecs.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Zero-length run: done pulse only.
    vecs.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // base<2 takes priority over count=0.
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Overflow: base=62 count=5 writes 62 and 63, then done+err.
    vecs.push_back(mk(1, 62, 5, 60, 61, 62, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 62, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 62, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 61, 62, 63, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 63, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 63, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // start held high through every state of a run: ignored, and lost in DONE.
    vecs.push_back(mk(1, 10, 1, 8, 9, 10, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 3, 7, 0, 0, 10, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 3, 7, 0, 0, 10, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 3, 7, 0, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 3, 7, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      start = vecs[i].start;
      base  = vecs[i].base;
      count = vecs[i].count;
      step();
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end
    start = 1'b0;

    // Fibonacci results of the first run in both RAM and register file.
    for (int k = 2; k <= 5; k++) begin
      logic [15:0] fib [6];
      fib[0] = 16'd1; fib[1] = 16'd1; fib[2] = 16'd2;
      fib[3] = 16'd3; fib[4] = 16'd5; fib[5] = 16'd8;
      check($sformatf("ram%0d", k), 32'(ram[k]), 32'(fib[k]));
      check($sformatf("reg%0d", k), 32'(rf[k]), 32'(fib[k]));
    end

    // Reset in the WAIT of the second result.
    start = 1'b1; base = AW'(2); count = AW'(4);
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("pre_reset_wait", 32'({addr3, busy, wea, wer}), 32'({AW'(3), 3'b100}));
    #2 rst_n = 1'b0;
    #1 check("async_reset", 32'(outs()), 32'd0);
    step();
    check("held_reset", 32'(outs()), 32'd0);
    rst_n = 1'b1;
    step();
    check("after_reset_idle", 32'(outs()), 32'd0);

    // Fresh single-result run: done in the 4th cycle after the accepting one.
    start = 1'b1; base = AW'(2); count = AW'(1);
    step();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 20) begin
      step();
      cyc++;
    end
    check("done_latency", 32'(cyc), 32'd4);
    check("done_no_err", 32'({err, busy}), 32'b01);
    check("reg2_after_reset", 32'(rf[2]), 32'd2);
    step();
    check("final_idle", 32'(outs()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
